// File: rtl/inst_queue_nw_pkg.sv
// Shared constants for the fetch-to-decode instruction queue: default geometry and
// the field layout of one queued entry {ex, excode, pd_pc, inst, pc}.
package inst_queue_nw_pkg;

   localparam int INST_Q_DEPTH = 16;
   localparam int INST_Q_ENQ_W = 2;
   localparam int INST_Q_DEQ_W = 2;

   localparam int PC_LSB     = 0;
   localparam int INST_LSB   = 32;
   localparam int PD_PC_LSB  = 64;
   localparam int EXCODE_LSB = 96;
   localparam int EX_BIT     = 101;
   localparam int PC_W       = 32;

   localparam int FIFO_TO_DS_BUS_WD = 102;

endpackage

// File: rtl/inst_queue_nw_lead_ones.sv
// Counts consecutive ones from lane 0 of an enqueue-valid mask and flags any set
// lane that follows a clear one (a non-thermometer mask).
module inst_q_lead_ones #(
   parameter int W = 2
) (
   input  logic [W-1:0]           valid_i,
   output logic [$clog2(W+1)-1:0] n_o,
   output logic                   gap_o
);

   logic seen_zero;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      n_o       = '0;
      gap_o     = 1'b0;
      seen_zero = 1'b0;
      for (int k = 0; k < W; k++) begin
         if (!valid_i[k])
            seen_zero = 1'b1;
         else if (seen_zero)
            gap_o = 1'b1;
         else
            n_o = n_o + 1'b1;
      end
   end

endmodule

// File: rtl/inst_queue_nw.sv
// Multi-lane instruction queue between I-cache return and decode: all-or-nothing
// group admission, up to DEQ_W issues per cycle, full drain on flush.
module inst_queue_nw
   import inst_queue_nw_pkg::*;
#(
   parameter int DEPTH  = INST_Q_DEPTH,
   parameter int ENQ_W  = INST_Q_ENQ_W,
   parameter int DEQ_W  = INST_Q_DEQ_W,
   parameter int DATA_W = FIFO_TO_DS_BUS_WD
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [ENQ_W-1:0]             in_valid,
   input  logic [ENQ_W*DATA_W-1:0]      in_data,
   output logic                         in_ready,
   input  logic [$clog2(DEQ_W+1)-1:0]   deq_cnt,
   output logic [DEQ_W-1:0]             out_valid,
   output logic [DEQ_W*DATA_W-1:0]      out_data,
   output logic [31:0]                  head_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [$clog2(DEPTH+1)-1:0]   free_cnt,
   output logic                         err_underflow,
   output logic                         err_gap
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int NW = $clog2(ENQ_W + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d, n_deq, n_enq_eff;
   logic [NW-1:0]     n_enq;
   logic              gap, do_enq, over_issue;
   logic              err_underflow_q, err_gap_q;

   inst_q_lead_ones #(.W(ENQ_W)) u_lead_ones (
      .valid_i (in_valid),
      .n_o     (n_enq),
      .gap_o   (gap)
   );

   // Admission looks only at registered occupancy, never at this cycle's issue.
   assign free_cnt   = CW'(DEPTH) - count_q;
   assign in_ready   = free_cnt >= CW'(ENQ_W);
   assign do_enq     = in_ready && !flush;
   assign over_issue = CW'(deq_cnt) > count_q;

   always_comb begin
      n_deq     = over_issue ? count_q : CW'(deq_cnt);
      n_enq_eff = do_enq ? CW'(n_enq) : '0;
      head_d    = head_q + PW'(n_deq);
      tail_d    = tail_q + PW'(n_enq_eff);
      count_d   = count_q + n_enq_eff - n_deq;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         err_underflow_q <= 1'b0;
         err_gap_q       <= 1'b0;
      end else begin
         if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
         end
         if (over_issue) err_underflow_q <= 1'b1;
         if (gap)        err_gap_q       <= 1'b1;
      end
   end

   // NOTE: the store has no reset; an entry is only observed once count covers it.
   always_ff @(posedge clk) begin
      if (do_enq && !reset) begin
         for (int k = 0; k < ENQ_W; k++) begin
            if (NW'(k) < n_enq)
               mem_q[tail_q + PW'(k)] <= in_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      out_valid = '0;
      out_data  = '0;
      head_pc   = '0;
      for (int k = 0; k < DEQ_W; k++) begin
         if (!flush && count_q > CW'(k)) begin
            out_valid[k]                  = 1'b1;
            out_data[k*DATA_W +: DATA_W]  = mem_q[head_q + PW'(k)];
         end
      end
      if (!flush && count_q != '0)
         head_pc = mem_q[head_q][PC_LSB +: PC_W];
   end

   assign count         = count_q;
   assign err_underflow = err_underflow_q;
   assign err_gap       = err_gap_q;

endmodule

// File: tb/tb_inst_queue_nw.sv
// Bench for inst_queue_nw: directed scenarios plus random traffic, scored against a
// queue-based model of admission, issue, flush and the sticky error flags.
module tb_inst_queue_nw;
   import inst_queue_nw_pkg::*;

   localparam int DEPTH  = 16;
   localparam int ENQ_W  = 2;
   localparam int DEQ_W  = 2;
   localparam int DATA_W = FIFO_TO_DS_BUS_WD;
   localparam int CW     = $clog2(DEPTH + 1);

   typedef logic [DATA_W-1:0] entry_t;

   logic                        clk = 1'b0;
   logic                        reset, flush;
   logic [ENQ_W-1:0]            in_valid;
   logic [ENQ_W*DATA_W-1:0]     in_data;
   logic                        in_ready;
   logic [$clog2(DEQ_W+1)-1:0]  deq_cnt;
   logic [DEQ_W-1:0]            out_valid;
   logic [DEQ_W*DATA_W-1:0]     out_data;
   logic [31:0]                 head_pc;
   logic [CW-1:0]               count, free_cnt;
   logic                        err_underflow, err_gap;

   inst_queue_nw #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .deq_cnt       (deq_cnt),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .head_pc       (head_pc),
      .count         (count),
      .free_cnt      (free_cnt),
      .err_underflow (err_underflow),
      .err_gap       (err_gap)
   );

   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;
   entry_t      model_q[$];
   bit          m_err_u, m_err_g;
   logic [31:0] next_pc = 32'h1000;
   logic [31:0] lane0_pc, cap_pc0, cap_pc1;
   logic [DEQ_W-1:0] cap_ov;

   function automatic entry_t mk_entry(input logic [31:0] pc);
      logic [69:0] r;
      r = {6'($urandom), $urandom, $urandom};
      return {r, pc};
   endfunction

   // One clock: drive inputs, score the outputs against the model, take the edge, update the model.
   task automatic step(input logic [1:0] v, input logic [1:0] dq, input logic fl, input logic rs);
      entry_t           ent [ENQ_W];
      int               n_enq, n_pop, sz;
      bit               gap, rdy;
      logic [DEQ_W-1:0] exp_ov;
      logic [DEQ_W*DATA_W-1:0] exp_od;
      logic [31:0]      exp_hp;
      for (int k = 0; k < ENQ_W; k++) ent[k] = mk_entry(next_pc + 32'(k));
      lane0_pc = next_pc;
      next_pc  = next_pc + 32'(ENQ_W);
      in_valid = v;
      in_data  = {ent[1], ent[0]};
      deq_cnt  = dq;
      flush    = fl;
      reset    = rs;
      #1;
      sz = model_q.size();
      exp_ov = '0; exp_od = '0; exp_hp = '0;
      for (int k = 0; k < DEQ_W; k++)
         if (!fl && sz > k) begin
            exp_ov[k] = 1'b1;
            exp_od[k*DATA_W +: DATA_W] = model_q[k];
         end
      if (!fl && sz > 0) exp_hp = model_q[0][31:0];
      cap_ov  = out_valid;
      cap_pc0 = out_data[31:0];
      cap_pc1 = out_data[DATA_W +: 32];

      tests_run++;
      if (count !== CW'(sz)) begin
         tests_failed++; $display("FAIL count: got %0d expected %0d", count, sz);
      end
      tests_run++;
      if (free_cnt !== CW'(DEPTH - sz)) begin
         tests_failed++; $display("FAIL free_cnt: got %0d expected %0d", free_cnt, DEPTH - sz);
      end
      tests_run++;
      if (in_ready !== ((DEPTH - sz) >= ENQ_W)) begin
         tests_failed++; $display("FAIL in_ready: got %b with occupancy %0d", in_ready, sz);
      end
      tests_run++;
      if (out_valid !== exp_ov) begin
         tests_failed++; $display("FAIL out_valid: got %b expected %b", out_valid, exp_ov);
      end
      tests_run++;
      if (out_data !== exp_od) begin
         tests_failed++; $display("FAIL out_data: got %h expected %h", out_data, exp_od);
      end
      tests_run++;
      if (head_pc !== exp_hp) begin
         tests_failed++; $display("FAIL head_pc: got %h expected %h", head_pc, exp_hp);
      end
      tests_run++;
      if (err_underflow !== m_err_u || err_gap !== m_err_g) begin
         tests_failed++;
         $display("FAIL err_flags: got u=%b g=%b expected u=%b g=%b", err_underflow, err_gap, m_err_u, m_err_g);
      end

      @(posedge clk);
      n_enq = 0;
      for (int k = 0; k < ENQ_W; k++) if (v[k] && n_enq == k) n_enq++;
      gap = (v >> n_enq) != 0;
      rdy = (DEPTH - sz) >= ENQ_W;
      if (rs) begin
         model_q.delete();
         m_err_u = 1'b0;
         m_err_g = 1'b0;
      end else begin
         if (gap) m_err_g = 1'b1;
         if (int'(dq) > sz) m_err_u = 1'b1;
         if (fl) model_q.delete();
         else begin
            n_pop = (int'(dq) > sz) ? sz : int'(dq);
            repeat (n_pop) void'(model_q.pop_front());
            if (rdy) for (int k = 0; k < n_enq; k++) model_q.push_back(ent[k]);
         end
      end
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && model_q.size() > 0; i++)
         step(2'b00, (model_q.size() >= 2) ? 2'd2 : 2'(model_q.size()), 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      step(2'b11, 2'd2, 1'b0, 1'b1);
      tests_run++;
      if (count !== '0 || free_cnt !== CW'(DEPTH) || in_ready !== 1'b1 || out_valid !== '0 || head_pc !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: count=%0d free=%0d rdy=%b ov=%b hp=%h expected 0/16/1/0/0",
                  count, free_cnt, in_ready, out_valid, head_pc);
      end
      step(2'b11, 2'd0, 1'b0, 1'b0);
      step(2'b11, 2'd0, 1'b0, 1'b0);
      step(2'b11, 2'd2, 1'b1, 1'b1);
      tests_run++;
      if (count !== '0 || out_valid !== '0 || err_underflow !== 1'b0 || err_gap !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_traffic: count=%0d ov=%b u=%b g=%b expected all zero",
                  count, out_valid, err_underflow, err_gap);
      end
      step(2'b00, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic test_fill();
      logic [31:0] first_pc;
      first_pc = next_pc;
      for (int i = 0; i < 8; i++) step(2'b11, 2'd0, 1'b0, 1'b0);
      tests_run++;
      if (count !== CW'(16) || free_cnt !== '0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_full: count=%0d free=%0d rdy=%b expected 16/0/0", count, free_cnt, in_ready);
      end
      tests_run++;
      if (out_data[31:0] !== first_pc) begin
         tests_failed++; $display("FAIL fill_first_pc: got %h expected %h", out_data[31:0], first_pc);
      end
      step(2'b11, 2'd0, 1'b0, 1'b0);
      tests_run++;
      if (count !== CW'(16)) begin
         tests_failed++; $display("FAIL fill_drop_9th: count=%0d expected 16", count);
      end
      step(2'b11, 2'd1, 1'b0, 1'b0);
      tests_run++;
      if (count !== CW'(15) || free_cnt !== CW'(1) || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_15: count=%0d free=%0d rdy=%b expected 15/1/0", count, free_cnt, in_ready);
      end
      step(2'b01, 2'd0, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_steady();
      logic [31:0] prev_pc;
      prev_pc = '0;
      step(2'b11, 2'd0, 1'b0, 1'b0);
      step(2'b11, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(2'b11, 2'd2, 1'b0, 1'b0);
         tests_run++;
         if (count !== CW'(4) || !(cap_pc0 > prev_pc && cap_pc1 > cap_pc0)) begin
            tests_failed++;
            $display("FAIL steady_order: count=%0d pcs %h,%h after %h expected count 4 and rising pcs",
                     count, cap_pc0, cap_pc1, prev_pc);
         end
         prev_pc = cap_pc1;
      end
      drain();
   endtask

   task automatic test_single();
      for (int i = 0; i < 4; i++) begin
         step(2'b01, 2'd0, 1'b0, 1'b0);
         tests_run++;
         if (count !== CW'(1) || out_valid !== 2'b01) begin
            tests_failed++; $display("FAIL single_one: count=%0d ov=%b expected 1/01", count, out_valid);
         end
         step(2'b00, 2'd1, 1'b0, 1'b0);
         tests_run++;
         if (count !== '0 || out_valid !== 2'b00) begin
            tests_failed++; $display("FAIL single_zero: count=%0d ov=%b expected 0/00", count, out_valid);
         end
      end
   endtask

   task automatic test_underflow();
      step(2'b01, 2'd0, 1'b0, 1'b0);
      step(2'b00, 2'd2, 1'b0, 1'b0);
      tests_run++;
      if (count !== '0 || err_underflow !== 1'b1) begin
         tests_failed++; $display("FAIL underflow: count=%0d u=%b expected 0/1", count, err_underflow);
      end
      step(2'b00, 2'd0, 1'b1, 1'b0);
      tests_run++;
      if (err_underflow !== 1'b1) begin
         tests_failed++; $display("FAIL underflow_sticky: u=%b expected 1", err_underflow);
      end
   endtask

   task automatic test_gap();
      step(2'b01, 2'd0, 1'b0, 1'b0);
      step(2'b10, 2'd0, 1'b0, 1'b0);
      tests_run++;
      if (count !== CW'(1) || err_gap !== 1'b1) begin
         tests_failed++; $display("FAIL gap: count=%0d g=%b expected 1/1", count, err_gap);
      end
      drain();
   endtask

   task automatic test_flush();
      logic [31:0] grp_pc;
      for (int i = 0; i < 3; i++) step(2'b11, 2'd0, 1'b0, 1'b0);
      step(2'b11, 2'd2, 1'b1, 1'b0);
      tests_run++;
      if (cap_ov !== 2'b00 || count !== '0 || in_ready !== 1'b1 || head_pc !== '0) begin
         tests_failed++;
         $display("FAIL flush: ov_in_flush=%b count=%0d rdy=%b hp=%h expected 00/0/1/0",
                  cap_ov, count, in_ready, head_pc);
      end
      step(2'b11, 2'd0, 1'b0, 1'b0);
      grp_pc = lane0_pc;
      tests_run++;
      if (cap_ov !== 2'b00 || out_valid !== 2'b11 || out_data[31:0] !== grp_pc) begin
         tests_failed++;
         $display("FAIL flush_refill: ov_same=%b ov_next=%b pc=%h expected 00/11/%h",
                  cap_ov, out_valid, out_data[31:0], grp_pc);
      end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; deq_cnt = '0;
      m_err_u = 1'b0; m_err_g = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_steady();
      test_single();
      test_underflow();
      test_gap();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/inst_queue_nw.md
Name: inst_queue_nw

Overview:
Parametrised multi-lane instruction queue between the instruction-cache return path and the decode stage. It generalises the fixed 2-in/2-out buffer to ENQ_W enqueue lanes and DEQ_W issue lanes over a DEPTH-entry circular store. It adds an explicit occupancy count, a free count and all-or-nothing admission, and defines behaviour for over-issue. It drains fully on a decode-stage flush.

Parameters:
DEPTH, 16, number of entries; power of two, must be >= ENQ_W+DEQ_W.
ENQ_W, 2, enqueue lanes per cycle (1..4).
DEQ_W, 2, issue lanes per cycle (1..4).
DATA_W, 102, entry width: {ex, excode[4:0], pd_pc[31:0], inst[31:0], pc[31:0]}.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
flush  in  1  decode-stage flush; discards all entries.
in_valid  in  ENQ_W  per-lane enqueue valid; lane 0 is oldest.
in_data  in  ENQ_W*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
in_ready  out  1  queue can accept a full ENQ_W group this cycle.
deq_cnt  in  $clog2(DEQ_W+1)  number of head entries consumed this cycle.
out_valid  out  DEQ_W  lane k valid when count > k and flush is low.
out_data  out  DEQ_W*DATA_W  lane k = entry[head+k], zero when not valid.
head_pc  out  32  pc field of entry[head], zero when the queue is empty.
count  out  $clog2(DEPTH+1)  occupancy.
free_cnt  out  $clog2(DEPTH+1)  DEPTH - count.
err_underflow  out  1  sticky: deq_cnt exceeded count.
err_gap  out  1  sticky: in_valid was not a thermometer mask.

Behaviour:
- Reset values: count=0, free_cnt=DEPTH, head=tail=0, in_ready=1, out_valid=0, out_data=0, head_pc=0, both error flags=0.
- Admission rule:
  - in_ready = (free_cnt >= ENQ_W), computed from registered state only; it does not depend on deq_cnt in the same cycle.
  - The enqueue count n_enq is the number of consecutive ones in in_valid starting at lane 0. Lanes after the first zero are dropped and set err_gap.
  - Enqueue happens only when in_ready=1 and flush=0. Lanes 0..n_enq-1 are written to entry[tail+k] mod DEPTH. tail advances by n_enq.
  - When in_ready=0 all lanes are dropped. The upstream holds or replays them; no partial acceptance.
- Issue rule:
  - n_deq = min(deq_cnt, count). If deq_cnt > count, err_underflow is set; head and count move only by count.
  - head advances by n_deq mod DEPTH.
- Simultaneous events: count_next = count + n_enq - n_deq in the same cycle. Pointers wrap mod DEPTH with no special case.
- Latency: an entry written at edge t is visible on out_valid/out_data in the cycle after edge t. There is no same-cycle bypass from in_data to out_data.
- Outputs out_valid, out_data and head_pc are combinational from the registered store, head and count, gated by flush.
- Flush:
  - In the flush cycle, out_valid=0 and enqueue is suppressed.
  - At the next edge, head=tail=count=0.
  - Error flags are not cleared by flush.
- Reset dominates flush and any enqueue or issue in the same cycle. Reset mid-traffic leaves no residual valid entries.
- Storage is plain registers with no reset on the data fields; validity is derived from count only.
- Full: count=DEPTH implies free_cnt=0 and in_ready=0; issue still proceeds.
- Empty: count=0 implies out_valid all zero and head_pc=0.

Decomposition:
- Shared header defines:
  - INST_Q_DEPTH, INST_Q_ENQ_W and INST_Q_DEQ_W defaults.
  - The entry field offsets (PC_LSB=0, INST_LSB=32, PD_PC_LSB=64, EXCODE_LSB=96, EX_BIT=101).
  - FIFO_TO_DS_BUS_WD=102.
- One sub-module, inst_q_lead_ones: combinational ENQ_W-bit leading-ones count plus gap detect. Everything else stays in the top module.

Test Plan:
All scenarios use DEPTH=16, ENQ_W=2, DEQ_W=2.
- Reset, then in_valid=2'b11 every cycle with deq_cnt=0 -> count reaches 16 after 8 accepts; in_ready=0 from the cycle count=15 (free_cnt=1); the 9th group is dropped; out_data lane0 pc = first enqueued pc.
- Steady state with count=4, in_valid=2'b11 and deq_cnt=2 -> count stays 4 and issued pcs are strictly in order across head/tail wrap (fill and drain 40 entries, compare against a scoreboard).
- Single-lane traffic, in_valid=2'b01 with deq_cnt=1 alternating with 0 -> count toggles 1/0; out_valid=2'b01 only.
- count=1 and deq_cnt=2 -> count=0 next cycle, err_underflow=1 and stays set through a later flush.
- in_valid=2'b10 -> nothing enqueued, count unchanged, err_gap=1.
- count=6, then flush with in_valid=2'b11 and deq_cnt=2 in the same cycle -> out_valid=0 in that cycle; count=0, in_ready=1 and head_pc=0 on the next cycle; a new group appears on out one cycle after its enqueue.
